// File: rtl/i2c_slave_apb_regs_if.sv
// APB-side register access bundle between the access FSM (master) and the
// I2C slave register bank (slave).
interface i2c_slave_apb_regs_if #(
    parameter int ADDR_W = 5
) ();
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        output rd_en, wr_en, paddr, pwdata,
        input  prdata, pslverr
    );

    modport slave (
        input  rd_en, wr_en, paddr, pwdata,
        output prdata, pslverr
    );
endinterface

// File: rtl/i2c_slave_apb_regs.sv
// APB register bank of the I2C slave: CTRL/OWN_ADDR/STATUS registers plus
// TX and RX byte FIFOs shared with the I2C byte engine.
module i2c_slave_apb_regs #(
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  pclk,
    input  logic                  preset,
    i2c_slave_apb_regs_if.slave   apb,
    input  logic                  tx_pop,
    output logic [7:0]            tx_data,
    output logic                  tx_empty,
    input  logic                  rx_push,
    input  logic [7:0]            rx_data,
    output logic                  rx_full,
    input  logic                  stop_det,
    output logic                  slv_en,
    output logic [6:0]            own_addr,
    output logic                  irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_OWN    = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_TXDATA = 3'd3;
    localparam logic [2:0] REG_RXDATA = 3'd4;

    logic [3:0]       ctrl_q, ctrl_d;
    logic [6:0]       own_addr_q, own_addr_d;
    logic             stop_flag_q, stop_flag_d;
    logic             rx_ovf_q, rx_ovf_d;
    logic [PTR_W:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PTR_W:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

    logic [FIFO_DEPTH*8-1:0] tx_mem, rx_mem;
    logic [7:0]       tx_head, rx_head;
    logic [2:0]       reg_idx;
    logic             en, tx_full, rx_empty;
    logic             tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok, status_wr;
    logic [31:0]      rd_data;
    logic             rd_err, wr_err;
    logic             unused_bits;

    assign reg_idx  = apb.paddr[4:2];
    assign en       = ctrl_q[0];

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[PTR_W] != tx_rd_q[PTR_W]) &&
                      (tx_wr_q[PTR_W-1:0] == tx_rd_q[PTR_W-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[PTR_W] != rx_rd_q[PTR_W]) &&
                      (rx_wr_q[PTR_W-1:0] == rx_rd_q[PTR_W-1:0]);

    assign tx_head  = tx_mem[{tx_rd_q[PTR_W-1:0], 3'b000} +: 8];
    assign rx_head  = rx_mem[{rx_rd_q[PTR_W-1:0], 3'b000} +: 8];
    assign tx_data  = tx_empty ? 8'h00 : tx_head;

    assign slv_en   = ctrl_q[0];
    assign own_addr = own_addr_q;
    assign irq      = (ctrl_q[1] & tx_empty) | (ctrl_q[2] & ~rx_empty) |
                      (ctrl_q[3] & stop_flag_q);

    assign unused_bits = ^{apb.pwdata[31:8], apb.paddr[1:0]};

    // A disabled slave never accepts bytes, so its FIFOs stay empty.
    assign tx_push_ok = apb.wr_en && (reg_idx == REG_TXDATA) && en && !tx_full;
    assign tx_pop_ok  = tx_pop && !tx_empty;
    assign rx_push_ok = rx_push && en && !rx_full;
    assign rx_pop_ok  = apb.rd_en && (reg_idx == REG_RXDATA) && !rx_empty;
    assign status_wr  = apb.wr_en && (reg_idx == REG_STATUS);

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        wr_err  = 1'b0;
        case (reg_idx)
            REG_CTRL:   rd_data = {28'd0, ctrl_q};
            REG_OWN:    rd_data = {25'd0, own_addr_q};
            REG_STATUS: rd_data = {26'd0, rx_ovf_q, stop_flag_q, rx_full,
                                   rx_empty, tx_full, tx_empty};
            REG_TXDATA: wr_err  = !en || tx_full;
            REG_RXDATA: begin
                rd_data = rx_empty ? 32'd0 : {24'd0, rx_head};
                rd_err  = rx_empty;
            end
            default: begin
                rd_err = 1'b1;
                wr_err = 1'b1;
            end
        endcase
        apb.prdata  = apb.rd_en ? rd_data : 32'd0;
        apb.pslverr = (apb.rd_en & rd_err) | (apb.wr_en & wr_err);
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        own_addr_d = own_addr_q;
        if (apb.wr_en && reg_idx == REG_CTRL) ctrl_d     = apb.pwdata[3:0];
        if (apb.wr_en && reg_idx == REG_OWN)  own_addr_d = apb.pwdata[6:0];

        // Hardware set wins over a simultaneous write-one-to-clear.
        stop_flag_d = stop_det | (stop_flag_q & ~(status_wr & apb.pwdata[4]));
        rx_ovf_d    = (rx_push & en & rx_full) |
                      (rx_ovf_q & ~(status_wr & apb.pwdata[5]));

        tx_wr_d = tx_wr_q + {{PTR_W{1'b0}}, tx_push_ok};
        tx_rd_d = tx_rd_q + {{PTR_W{1'b0}}, tx_pop_ok};
        rx_wr_d = rx_wr_q + {{PTR_W{1'b0}}, rx_push_ok};
        rx_rd_d = rx_rd_q + {{PTR_W{1'b0}}, rx_pop_ok};

        // Flush on the same edge that clears EN, and hold flushed while off.
        if (!ctrl_d[0]) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
            rx_wr_d = '0;
            rx_rd_d = '0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_q      <= 4'd0;
            own_addr_q  <= 7'h50;
            stop_flag_q <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            own_addr_q  <= own_addr_d;
            stop_flag_q <= stop_flag_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [7:0] tx_ent_q, tx_ent_d;
            logic [7:0] rx_ent_q, rx_ent_d;

            always_comb begin
                tx_ent_d = tx_ent_q;
                rx_ent_d = rx_ent_q;
                if (tx_push_ok && tx_wr_q[PTR_W-1:0] == PTR_W'(gi))
                    tx_ent_d = apb.pwdata[7:0];
                if (rx_push_ok && rx_wr_q[PTR_W-1:0] == PTR_W'(gi))
                    rx_ent_d = rx_data;
            end

            always_ff @(posedge pclk or posedge preset) begin
                if (preset) begin
                    tx_ent_q <= 8'd0;
                    rx_ent_q <= 8'd0;
                end else begin
                    tx_ent_q <= tx_ent_d;
                    rx_ent_q <= rx_ent_d;
                end
            end

            assign tx_mem[gi*8 +: 8] = tx_ent_q;
            assign rx_mem[gi*8 +: 8] = rx_ent_q;
        end
    endgenerate
endmodule

// File: tb/tb_i2c_slave_apb_regs.sv
// Bench for the I2C slave register bank: directed scenarios plus a
// randomized run against a queue-based model of the register map.
module tb_i2c_slave_apb_regs;
    localparam int D = 4;

    logic       pclk = 1'b0;
    logic       preset;
    logic       tx_pop, rx_push, stop_det;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_empty, rx_full, slv_en, irq;
    logic [6:0] own_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    i2c_slave_apb_regs_if #(.ADDR_W(5)) bus ();

    i2c_slave_apb_regs #(.ADDR_W(5), .FIFO_DEPTH(D)) dut (
        .pclk     (pclk),
        .preset   (preset),
        .apb      (bus.slave),
        .tx_pop   (tx_pop),
        .tx_data  (tx_data),
        .tx_empty (tx_empty),
        .rx_push  (rx_push),
        .rx_data  (rx_data),
        .rx_full  (rx_full),
        .stop_det (stop_det),
        .slv_en   (slv_en),
        .own_addr (own_addr),
        .irq      (irq)
    );

    task automatic drive(input logic rd, input logic wr, input logic [4:0] a,
                         input logic [31:0] wd, input logic pop, input logic push,
                         input logic [7:0] rxd, input logic stp,
                         output logic [31:0] rdata, output logic err);
        @(negedge pclk);
        bus.rd_en = rd; bus.wr_en = wr; bus.paddr = a; bus.pwdata = wd;
        tx_pop = pop; rx_push = push; rx_data = rxd; stop_det = stp;
        #2;
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge pclk);
        #1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0; stop_det = 1'b0;
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] wd, output logic err);
        logic [31:0] d;
        drive(1'b0, 1'b1, a, wd, 1'b0, 1'b0, 8'h00, 1'b0, d, err);
        $display("WR  addr=0x%02h data=0x%08h err=%0b", a, wd, err);
    endtask

    task automatic apb_rd(input logic [4:0] a, output logic [31:0] d, output logic err);
        drive(1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 8'h00, 1'b0, d, err);
        $display("RD  addr=0x%02h data=0x%08h err=%0b", a, d, err);
    endtask

    task automatic eng(input logic pop, input logic push, input logic [7:0] rxd, input logic stp);
        logic [31:0] d;
        logic e;
        drive(1'b0, 1'b0, 5'd0, 32'd0, pop, push, rxd, stp, d, e);
        $display("ENG pop=%0b push=%0b rx=0x%02h stop=%0b tx_data=0x%02h", pop, push, rxd, stp, tx_data);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic e;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        n_cmp++; if (tx_empty !== 1'b1 || rx_full !== 1'b0 || tx_data !== 8'h00 || slv_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_ports got tx_empty=%0b rx_full=%0b tx_data=%02h slv_en=%0b exp 1/0/00/0",
                              tx_empty, rx_full, tx_data, slv_en); end
        n_cmp++; if (bus.prdata !== 32'd0 || bus.pslverr !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_bus got prdata=%h pslverr=%0b exp 0/0", bus.prdata, bus.pslverr); end
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h05 || e !== 1'b0) begin n_bad++; $display("FAIL reset_status got=%h/%0b exp=05/0", d, e); end
        apb_rd(5'h04, d, e);
        n_cmp++; if (d !== 32'h50 || own_addr !== 7'h50) begin n_bad++; $display("FAIL reset_own got=%h port=%h exp=50", d, own_addr); end
        apb_rd(5'h00, d, e);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_tx_fifo;
        logic [31:0] d;
        logic e;
        logic [7:0] bytes [4];
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        apb_wr(5'h00, 32'h1, e);
        for (int i = 0; i < 4; i++) begin
            apb_wr(5'h0C, {24'hFFFFFF, bytes[i]}, e);
            n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL tx_push_err[%0d] got=%0b exp=0", i, e); end
        end
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h06) begin n_bad++; $display("FAIL tx_full_status got=%h exp=06", d); end
        apb_wr(5'h0C, 32'hEE, e);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL tx_overflow_err got=%0b exp=1", e); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tx_data !== bytes[i]) begin n_bad++; $display("FAIL tx_order[%0d] got=%h exp=%h", i, tx_data, bytes[i]); end
            eng(1'b1, 1'b0, 8'h00, 1'b0);
        end
        n_cmp++; if (tx_empty !== 1'b1 || tx_data !== 8'h00) begin
            n_bad++; $display("FAIL tx_drained got empty=%0b data=%h exp 1/00", tx_empty, tx_data); end
        eng(1'b1, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL tx_pop_empty got=%0b exp=1", tx_empty); end
    endtask

    task automatic test_rx_overflow;
        logic [31:0] d;
        logic e;
        apb_wr(5'h00, 32'h5, e);
        for (int i = 0; i < 5; i++) begin
            eng(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
            if (i == 0) begin
                n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rx_irq got=%0b exp=1", irq); end
            end
        end
        n_cmp++; if (rx_full !== 1'b1) begin n_bad++; $display("FAIL rx_full got=%0b exp=1", rx_full); end
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h29) begin n_bad++; $display("FAIL rx_ovf_status got=%h exp=29", d); end
        for (int i = 0; i < 4; i++) begin
            apb_rd(5'h10, d, e);
            n_cmp++; if (d !== 32'(8'h11 + i) || e !== 1'b0) begin
                n_bad++; $display("FAIL rx_order[%0d] got=%h/%0b exp=%h/0", i, d, e, 8'h11 + i); end
        end
        apb_rd(5'h10, d, e);
        n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL rx_underflow got=%h/%0b exp=0/1", d, e); end
        apb_wr(5'h08, 32'h20, e);
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h05 || irq !== 1'b0) begin n_bad++; $display("FAIL rx_ovf_w1c got=%h irq=%0b exp=05/0", d, irq); end
    endtask

    task automatic test_stop_w1c;
        logic [31:0] d;
        logic e;
        apb_wr(5'h00, 32'h9, e);
        eng(1'b0, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL stop_irq got=%0b exp=1", irq); end
        drive(1'b0, 1'b1, 5'h08, 32'h10, 1'b0, 1'b0, 8'h00, 1'b1, d, e);
        $display("WR  addr=0x08 data=0x00000010 with stop_det=1");
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h15 || irq !== 1'b1) begin n_bad++; $display("FAIL stop_set_beats_clear got=%h irq=%0b exp=15/1", d, irq); end
        apb_wr(5'h08, 32'h10, e);
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h05 || irq !== 1'b0) begin n_bad++; $display("FAIL stop_w1c got=%h irq=%0b exp=05/0", d, irq); end
    endtask

    task automatic test_disable_flush;
        logic [31:0] d;
        logic e;
        apb_wr(5'h00, 32'h1, e);
        eng(1'b0, 1'b1, 8'h33, 1'b0);
        eng(1'b0, 1'b1, 8'h44, 1'b0);
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h01) begin n_bad++; $display("FAIL dis_prefill got=%h exp=01", d); end
        apb_wr(5'h00, 32'h0, e);
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h05 || slv_en !== 1'b0) begin n_bad++; $display("FAIL dis_flush got=%h en=%0b exp=05/0", d, slv_en); end
        for (int i = 0; i < 5; i++) eng(1'b0, 1'b1, 8'h55, 1'b0);
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h05 || rx_full !== 1'b0) begin n_bad++; $display("FAIL dis_rx_ignored got=%h full=%0b exp=05/0", d, rx_full); end
        apb_wr(5'h0C, 32'h77, e);
        n_cmp++; if (e !== 1'b1 || tx_empty !== 1'b1) begin n_bad++; $display("FAIL dis_tx_err got=%0b empty=%0b exp=1/1", e, tx_empty); end
    endtask

    task automatic test_bad_addr;
        logic [31:0] d;
        logic e;
        apb_rd(5'h18, d, e);
        n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL bad_rd_18 got=%h/%0b exp=0/1", d, e); end
        apb_rd(5'h14, d, e);
        n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_bad++; $display("FAIL bad_rd_14 got=%h/%0b exp=0/1", d, e); end
        apb_wr(5'h1C, 32'hFFFF_FFFF, e);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL bad_wr_1c got=%0b exp=1", e); end
        apb_wr(5'h06, 32'hFFFF_FF75, e);
        apb_rd(5'h07, d, e);
        n_cmp++; if (d !== 32'h75 || own_addr !== 7'h75) begin n_bad++; $display("FAIL own_lowbits got=%h port=%h exp=75", d, own_addr); end
        apb_rd(5'h0C, d, e);
        n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL txdata_read got=%h/%0b exp=0/0", d, e); end
        apb_wr(5'h10, 32'h12, e);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rxdata_write got=%0b exp=0", e); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        logic e;
        apb_wr(5'h00, 32'hF, e);
        apb_wr(5'h0C, 32'h9A, e);
        eng(1'b0, 1'b1, 8'h5A, 1'b1);
        @(negedge pclk);
        bus.wr_en = 1'b1; bus.paddr = 5'h0C; bus.pwdata = 32'hBC;
        #2 preset = 1'b1;
        #1;
        $display("RST asserted mid-fill");
        n_cmp++; if (tx_empty !== 1'b1 || tx_data !== 8'h00 || rx_full !== 1'b0) begin
            n_bad++; $display("FAIL async_fifo got empty=%0b data=%h full=%0b exp 1/00/0", tx_empty, tx_data, rx_full); end
        n_cmp++; if (slv_en !== 1'b0 || own_addr !== 7'h50 || irq !== 1'b0) begin
            n_bad++; $display("FAIL async_regs got en=%0b own=%h irq=%0b exp 0/50/0", slv_en, own_addr, irq); end
        bus.wr_en = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        #1;
        n_cmp++; if (bus.prdata !== 32'h0 || bus.pslverr !== 1'b0) begin
            n_bad++; $display("FAIL async_bus got=%h/%0b exp=0/0", bus.prdata, bus.pslverr); end
        @(negedge pclk);
        preset = 1'b0;
        apb_rd(5'h08, d, e);
        n_cmp++; if (d !== 32'h05) begin n_bad++; $display("FAIL async_status got=%h exp=05", d); end
    endtask

    task automatic test_random;
        logic [7:0] tx_q [$];
        logic [7:0] rx_q [$];
        logic [3:0] m_ctrl = 4'd0;
        logic [6:0] m_own  = 7'h50;
        logic m_stop = 1'b0, m_ovf = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int op, idx;
            logic rd, wr, pop, push, stp, en, e, exp_err, exp_irq;
            logic [4:0] a;
            logic [31:0] wd, d, exp_d;
            logic [7:0] rxd, exp_tx;
            op  = $urandom_range(0, 3);
            rd  = (op == 1);
            wr  = (op >= 2);
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) idx = $urandom_range(0, 4);
            a   = {3'(idx), 2'($urandom)};
            wd  = $urandom;
            if (idx == 0 && $urandom_range(0, 4) != 0) wd[0] = 1'b1;
            pop  = ($urandom_range(0, 9) < 3);
            push = ($urandom_range(0, 9) < 3);
            stp  = ($urandom_range(0, 9) == 0);
            rxd  = 8'($urandom);

            exp_tx  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
            exp_irq = (m_ctrl[1] && tx_q.size() == 0) || (m_ctrl[2] && rx_q.size() > 0) || (m_ctrl[3] && m_stop);
            n_cmp++; if (tx_data !== exp_tx || tx_empty !== (tx_q.size() == 0)) begin
                n_bad++; $display("FAIL rnd_tx[%0d] got=%h/%0b exp=%h/%0b", n, tx_data, tx_empty, exp_tx, tx_q.size() == 0); end
            n_cmp++; if (rx_full !== (rx_q.size() == D) || irq !== exp_irq) begin
                n_bad++; $display("FAIL rnd_flags[%0d] got full=%0b irq=%0b exp %0b/%0b", n, rx_full, irq, rx_q.size() == D, exp_irq); end
            n_cmp++; if (slv_en !== m_ctrl[0] || own_addr !== m_own) begin
                n_bad++; $display("FAIL rnd_ctrl[%0d] got en=%0b own=%h exp %0b/%h", n, slv_en, own_addr, m_ctrl[0], m_own); end

            exp_d = 32'd0;
            exp_err = 1'b0;
            en = m_ctrl[0];
            case (idx)
                0: exp_d = {28'd0, m_ctrl};
                1: exp_d = {25'd0, m_own};
                2: exp_d = {26'd0, m_ovf, m_stop, rx_q.size() == D, rx_q.size() == 0,
                            tx_q.size() == D, tx_q.size() == 0};
                3: exp_err = wr && (!en || tx_q.size() == D);
                4: begin
                    if (rx_q.size() == 0) exp_err = rd;
                    else exp_d = {24'd0, rx_q[0]};
                end
                default: exp_err = rd || wr;
            endcase
            if (!rd) exp_d = 32'd0;

            drive(rd, wr, a, wd, pop, push, rxd, stp, d, e);
            $display("RND %0d rd=%0b wr=%0b addr=0x%02h wd=0x%08h pop=%0b push=%0b stop=%0b -> prdata=0x%08h err=%0b",
                     n, rd, wr, a, wd, pop, push, stp, d, e);
            n_cmp++; if (d !== exp_d || e !== exp_err) begin
                n_bad++; $display("FAIL rnd_bus[%0d] got=%h/%0b exp=%h/%0b", n, d, e, exp_d, exp_err); end

            begin
                logic txp, txo, rxp, rxo, ovf_set, clr;
                txp = wr && idx == 3 && en && tx_q.size() < D;
                txo = pop && tx_q.size() > 0;
                rxp = push && en && rx_q.size() < D;
                rxo = rd && idx == 4 && rx_q.size() > 0;
                ovf_set = push && en && rx_q.size() == D;
                clr = wr && idx == 2;
                if (txo) void'(tx_q.pop_front());
                if (txp) tx_q.push_back(wd[7:0]);
                if (rxo) void'(rx_q.pop_front());
                if (rxp) rx_q.push_back(rxd);
                m_stop = stp || (m_stop && !(clr && wd[4]));
                m_ovf  = ovf_set || (m_ovf && !(clr && wd[5]));
                if (wr && idx == 0) m_ctrl = wd[3:0];
                if (wr && idx == 1) m_own = wd[6:0];
                if (!m_ctrl[0]) begin
                    tx_q.delete();
                    rx_q.delete();
                end
            end
        end
    endtask

    initial begin
        preset = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0; stop_det = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        #1;
        test_reset;
        test_tx_fifo;
        test_rx_overflow;
        test_stop_w1c;
        test_disable_flush;
        test_bad_addr;
        test_async_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
